// File: rtl/des_pkg.sv
// Shared types, widths and the key-schedule rotation helper for the iterative DES round controller.
package des_pkg;
    localparam int          HALF_W      = 32;
    localparam int          CD_W        = 56;
    localparam int          SUB_W       = 48;
    localparam int          NROUNDS     = 16;
    localparam logic [15:0] SHIFT1_MASK = 16'h8103;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Rotate one 28-bit key half by 1 or 2 places, left or right.
    function automatic logic [27:0] rot28(input logic [27:0] x, input logic right, input logic two);
        logic [55:0] d;
        d = {x, x};
        case ({right, two})
            2'b00:   rot28 = d[54:27];
            2'b01:   rot28 = d[53:26];
            2'b10:   rot28 = d[28:1];
            default: rot28 = d[29:2];
        endcase
    endfunction
endpackage

// File: rtl/des_key_rotator.sv
// Combinational {C,D} rotator: both 28-bit halves move by the same amount and direction, independently.
module des_key_rotator
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd,
    input  logic            right,
    input  logic            two,
    output logic [CD_W-1:0] cd_rot
);
    assign cd_rot = {rot28(cd[55:28], right, two), rot28(cd[27:0], right, two)};
endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: holds L/R and C/D, steps one round per clock through an external
// combinational f-path, with valid/ready hand-off on both the input and the result side.
module des_round_ctrl #(
    parameter logic [15:0] SHIFT1_MASK = des_pkg::SHIFT1_MASK
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          decrypt,
    input  logic [2*des_pkg::HALF_W-1:0]  blk_in,
    input  logic [des_pkg::CD_W-1:0]      key_cd,
    output logic [des_pkg::HALF_W-1:0]    f_r,
    output logic [des_pkg::CD_W-1:0]      f_cd,
    input  logic [des_pkg::HALF_W-1:0]    f_out,
    output logic [3:0]                    round_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*des_pkg::HALF_W-1:0]  blk_out
);
    import des_pkg::*;

    state_t            state;
    logic [HALF_W-1:0] l;
    logic [HALF_W-1:0] r;
    logic [CD_W-1:0]   cd;
    logic [CD_W-1:0]   cd_next;
    logic [CD_W-1:0]   cd_load;
    logic              dir;
    logic [3:0]        amt_idx;
    logic              last;

    // Decrypt walks the schedule backwards, so it reads the shift mask from the far end.
    assign amt_idx = dir ? (4'd15 - round_idx) : (round_idx + 4'd1);
    assign last    = (round_idx == 4'(NROUNDS - 1));

    des_key_rotator u_step (
        .cd     (cd),
        .right  (dir),
        .two    (~SHIFT1_MASK[amt_idx]),
        .cd_rot (cd_next)
    );

    // Encrypt starts from the K1 source, i.e. the loaded key already rotated left once.
    des_key_rotator u_load (
        .cd     (key_cd),
        .right  (1'b0),
        .two    (1'b0),
        .cd_rot (cd_load)
    );

    assign f_r  = r;
    assign f_cd = cd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            l         <= '0;
            r         <= '0;
            cd        <= '0;
            dir       <= 1'b0;
            round_idx <= '0;
            blk_out   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        l         <= blk_in[63:32];
                        r         <= blk_in[31:0];
                        cd        <= decrypt ? key_cd : cd_load;
                        dir       <= decrypt;
                        round_idx <= '0;
                        in_ready  <= 1'b0;
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    l         <= r;
                    r         <= l ^ f_out;
                    cd        <= cd_next;
                    round_idx <= round_idx + 4'd1;
                    // The final round leaves the halves unswapped in the result.
                    if (last) begin
                        blk_out   <= {l ^ f_out, r};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: wraps the sequencer with IP/FP/PC-1/PC-2 and a DES f-path model.
module tb_des_round_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        decrypt = 1'b0;
    logic [63:0] blk_in = '0;
    logic [55:0] key_cd = '0;
    logic [31:0] f_r;
    logic [55:0] f_cd;
    logic [31:0] f_out;
    logic [3:0]  round_idx;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] blk_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int IP_T[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int SHIFTS[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int CUM[16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};
    localparam int SB[512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] rr, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  b;
        for (int i = 0; i < 48; i++) x[47-i] = rr[32-E_T[i]];
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            b = x[47-6*i -: 6];
            s[31-4*i -: 4] = 4'(SB[i*64 + int'({b[5], b[0]})*16 + int'(b[4:1])]);
        end
        for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
        return o;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        logic [55:0] d;
        d = {x, x};
        return d[55-n -: 28];
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        logic [55:0] cd;
        logic [47:0] ks[16];
        logic [31:0] l, r, t;
        cd = pc1_f(key);
        for (int i = 0; i < 16; i++) begin
            cd = {rotl28(cd[55:28], SHIFTS[i]), rotl28(cd[27:0], SHIFTS[i])};
            ks[i] = pc2_f(cd);
        end
        {l, r} = ip_f(blk);
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_func(r, ks[dec ? 15 - i : i]);
            l = t;
        end
        return fp_f({r, l});
    endfunction

    assign f_out = f_func(f_r, pc2_f(f_cd));

    des_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decrypt   (decrypt),
        .blk_in    (blk_in),
        .key_cd    (key_cd),
        .f_r       (f_r),
        .f_cd      (f_cd),
        .f_out     (f_out),
        .round_idx (round_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_out   (blk_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " ctrl"}, {out_valid, in_ready, round_idx}, {1'b0, 1'b1, 4'd0});
        chk({name, " blk_out"}, blk_out, 64'h0);
        chk({name, " f_r/f_cd"}, {f_r, f_cd}, 88'h0);
    endtask

    task automatic run_block(input string name, input logic [63:0] key, input logic [63:0] din,
                             input logic dec, input logic [63:0] exp);
        int n;
        chk({name, " in_ready idle"}, in_ready, 1'b1);
        in_valid = 1'b1;
        decrypt  = dec;
        blk_in   = ip_f(din);
        key_cd   = pc1_f(key);
        step();
        // Scramble the inputs: only the accept edge may have sampled them.
        in_valid = 1'b0;
        decrypt  = ~dec;
        blk_in   = ~blk_in;
        key_cd   = ~key_cd;
        chk({name, " accepted"}, {in_ready, round_idx}, {1'b0, 4'd0});
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({name, " latency"}, n, 16);
        chk({name, " result"}, fp_f(blk_out), exp);
        if (dec) chk({name, " cd restored"}, f_cd, pc1_f(key));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, " handoff"}, {out_valid, in_ready}, 2'b01);
    endtask

    typedef struct {
        logic [63:0] key;
        logic [63:0] din;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];
    logic [63:0] bk[4];
    logic [63:0] bd[4];
    logic        bdec[4];

    initial begin
        int n;
        int prev;
        logic [63:0] expv;

        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        vecs[2] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58};
        vecs[4] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
        vecs[5] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};
        bk   = '{64'h133457799BBCDFF1, 64'hA1B2C3D4E5F60718, 64'h0E329232EA6D0D73, 64'hFEDCBA9876543210};
        bd   = '{64'h0123456789ABCDEF, 64'h5555AAAA3333CCCC, 64'h0000000000000000, 64'hDEADBEEFCAFEF00D};
        bdec = '{1'b0, 1'b1, 1'b1, 1'b0};

        #12;
        check_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].din, vecs[i].dec, vecs[i].exp);

        // Key rotation: D half holds a single 1 that must walk through the cumulative shift schedule.
        in_valid = 1'b1;
        decrypt  = 1'b0;
        key_cd   = 56'h1;
        blk_in   = 64'h0123456789ABCDEF;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("rot round %0d", k + 1), {round_idx, f_cd}, {4'(k), 28'h0, rotl28(28'h1, CUM[k])});
            step();
        end
        chk("rot done", {out_valid, in_ready}, 2'b10);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Stall in DONE with in_valid pushing a new block.
        in_valid = 1'b1;
        decrypt  = 1'b0;
        blk_in   = ip_f(64'h0123456789ABCDEF);
        key_cd   = pc1_f(64'h133457799BBCDFF1);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk("hold first", fp_f(blk_out), 64'h85E813540F0AB405);
        in_valid = 1'b1;
        blk_in   = 64'hFFFF0000FFFF0000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("hold cycle %0d", k), {out_valid, in_ready, blk_out},
                {1'b1, 1'b0, ip_f(64'h85E813540F0AB405)});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold release", {out_valid, in_ready}, 2'b01);

        // Abort mid-block with an asynchronous reset.
        in_valid = 1'b1;
        decrypt  = 1'b0;
        blk_in   = ip_f(64'h0123456789ABCDEF);
        key_cd   = pc1_f(64'h133457799BBCDFF1);
        step();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd7 && n < 20) begin
            step();
            n++;
        end
        chk("reach idx7", round_idx, 4'd7);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("abort async");
        step();
        check_reset_outputs("abort held");
        rst = 1'b0;
        step();
        run_block("after abort", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);

        // Back-to-back with both handshakes tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            key_cd  = pc1_f(bk[k]);
            blk_in  = ip_f(bd[k]);
            decrypt = bdec[k];
            expv    = des_model(bk[k], bd[k], bdec[k]);
            n = 0;
            while (!in_ready && n < 40) begin
                step();
                n++;
            end
            step();
            n = 0;
            while (!out_valid && n < 40) begin
                step();
                n++;
            end
            chk($sformatf("b2b result %0d", k), fp_f(blk_out), expv);
            if (k > 0) chk($sformatf("b2b period %0d", k), cyc - prev, 18);
            prev = cyc;
        end
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        chk("b2b idle", {out_valid, in_ready}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
